// File: rtl/button_pkg.sv
// Shared definitions for the button event generator: event codes and FSM states.
package button_pkg;

  localparam int unsigned EV_W = 2;

  localparam logic [EV_W-1:0] EV_PRESS   = 2'b00;
  localparam logic [EV_W-1:0] EV_RELEASE = 2'b01;
  localparam logic [EV_W-1:0] EV_LONG    = 2'b10;
  localparam logic [EV_W-1:0] EV_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    IDLE   = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } state_t;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous event queue with registered head/flags.
// Ports:
//   live_clock, rst (async active-low)
//   push, push_data : enqueue request (ignored when full unless a pop happens too)
//   pop             : dequeue request (ignored when empty)
//   head            : oldest entry, valid while valid = 1
//   valid/empty/full: registered occupancy flags
module event_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         live_clock,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  head_n;
  logic          do_push, do_pop;

  // Pointer/count update; a full FIFO still accepts a push when it pops too.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_n    = do_pop  ? rd_ptr + AW'(1) : rd_ptr;
    wr_n    = do_push ? wr_ptr + AW'(1) : wr_ptr;
    cnt_n   = cnt;
    if (do_push && !do_pop) begin
      cnt_n = cnt + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_n = cnt - CW'(1);
    end
    // The new head is the word being written whenever it lands on the next read slot.
    head_n = (do_push && (wr_ptr == rd_n)) ? push_data : mem[rd_n];
  end

  always_ff @(posedge live_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge live_clock or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
      valid  <= 1'b0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      cnt    <= cnt_n;
      head   <= head_n;
      valid  <= (cnt_n != '0);
      empty  <= (cnt_n == '0);
      full   <= (cnt_n == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into queued PRESS/RELEASE/LONG/REPEAT events.
// Ports:
//   live_clock, rst (async active-low)
//   clean    : debounced button level
//   ev_ready : consumer takes the head event this cycle
//   ovf_clr  : clears the sticky overflow flag
//   ev_valid, ev_code : head event of the queue
//   overflow : sticky, an event was dropped on a full queue
//   held     : button is in HOLD or REPEAT
module button_event_gen
  import button_pkg::*;
#(
  parameter logic        PRESS_LEVEL   = 1'b0,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic            live_clock,
  input  logic            rst,
  input  logic            clean,
  input  logic            ev_ready,
  input  logic            ovf_clr,
  output logic            ev_valid,
  output logic [EV_W-1:0] ev_code,
  output logic            overflow,
  output logic            held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               pressed_q;
  logic               push_c;
  logic [EV_W-1:0]    push_code_c;
  logic               fifo_full, fifo_empty, pop_c, drop_c;

  // Input register; resets to "pressed" so ARM waits for a real sampled release.
  always_ff @(posedge live_clock or negedge rst) begin
    if (!rst) begin
      pressed_q <= 1'b1;
    end else begin
      pressed_q <= (clean == PRESS_LEVEL);
    end
  end

  // State, counter and status registers.
  always_ff @(posedge live_clock or negedge rst) begin
    if (!rst) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      held     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      held     <= (state_n == HOLD) || (state_n == REPEAT);
      overflow <= drop_c ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
    end
  end

  // Next-state logic; release takes priority over a terminal count.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ARM:     if (!pressed_q) state_n = IDLE;
      IDLE:    if (pressed_q)  state_n = HOLD;
      HOLD: begin
        if (!pressed_q)              state_n = IDLE;
        else if (cnt_q == LONG_LAST) state_n = REPEAT;
      end
      REPEAT:  if (!pressed_q) state_n = IDLE;
      default: state_n = ARM;
    endcase
  end

  // Event pushes and counter control; counter is zero outside HOLD/REPEAT.
  always_comb begin
    push_c      = 1'b0;
    push_code_c = EV_PRESS;
    cnt_n       = '0;
    case (state_q)
      IDLE: begin
        if (pressed_q) begin
          push_c      = 1'b1;
          push_code_c = EV_PRESS;
        end
      end
      HOLD: begin
        if (!pressed_q) begin
          push_c      = 1'b1;
          push_code_c = EV_RELEASE;
        end else if (cnt_q == LONG_LAST) begin
          push_c      = 1'b1;
          push_code_c = EV_LONG;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!pressed_q) begin
          push_c      = 1'b1;
          push_code_c = EV_RELEASE;
        end else if (cnt_q == REPEAT_LAST) begin
          push_c      = 1'b1;
          push_code_c = EV_REPEAT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // A push is lost only when the queue is full and nothing leaves this cycle.
  always_comb begin
    pop_c  = ev_ready && !fifo_empty;
    drop_c = push_c && fifo_full && !pop_c;
  end

  event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .live_clock (live_clock),
    .rst        (rst),
    .push       (push_c),
    .push_data  (push_code_c),
    .pop        (pop_c),
    .head       (ev_code),
    .valid      (ev_valid),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

endmodule
